noncoh_acc_core: RTL and testbench

NONCOH_ACC_CORE -- requirements
Module: noncoh_acc_core

---
 rtl/noncoh_acc_core.sv | 151 +++++++++++++++
 tb/tb_noncoh_acc_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/noncoh_acc_core.sv
// Noncoherent accumulation core: takes a coherent I/Q sample, computes an
// alpha-max/beta-min amplitude, scales it, adds a rescaled stored sum and
// clips the result. Per-frame peak value/index and exceed count are tracked.
// Latency is three cycles from coh_valid to out_valid.
module noncoh_acc_core #(
  parameter int COH_W   = 10,
  parameter int NC_W    = 8,
  parameter int SHIFT_W = 4,
  parameter int IDX_W   = 10,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      coh_valid,
  input  logic signed [COH_W-1:0]   coh_i,
  input  logic signed [COH_W-1:0]   coh_q,
  input  logic        [SHIFT_W-1:0] coh_exp,
  input  logic        [SHIFT_W-1:0] coh_shift,
  input  logic                      frame_start,
  input  logic                      first_pass,
  input  logic        [1:0]         extra_shift,
  input  logic        [NC_W-1:0]    noncoh_data,
  input  logic        [SHIFT_W-1:0] noncoh_shift,
  output logic                      out_valid,
  output logic        [NC_W:0]      noncoh_out,
  output logic                      exceed,
  output logic        [NC_W:0]      peak_value,
  output logic        [IDX_W-1:0]   peak_index,
  output logic        [CNT_W-1:0]   exceed_cnt
);

  localparam int AMP_W  = COH_W + 1;
  localparam int SUM_W  = COH_W + 2;
  // Wide enough to hold any sum plus the largest rounding constant.
  localparam int WIDE_W = SUM_W + 2**SHIFT_W;
  localparam int OUT_W  = NC_W + 1;

  localparam logic signed [COH_W-1:0] S_MIN    = {1'b1, {(COH_W-1){1'b0}}};
  localparam logic        [COH_W-1:0] ABS_MAX  = {1'b0, {(COH_W-1){1'b1}}};
  localparam logic        [WIDE_W-1:0] CLIP_LIM = WIDE_W'(2**OUT_W - 2);
  localparam logic        [CNT_W-1:0] CNT_MAX  = '1;

  // Magnitude with the most negative code saturated to the largest positive.
  function automatic logic [COH_W-1:0] abs_sat(input logic signed [COH_W-1:0] x);
    if (x == S_MIN) return ABS_MAX;
    else if (x[COH_W-1]) return $unsigned(-x);
    else return $unsigned(x);
  endfunction

  // Right shift with round-half-up; shift of zero passes the value through.
  function automatic logic [WIDE_W-1:0] rnd_shr(input logic [WIDE_W-1:0] x,
                                                input logic [SHIFT_W-1:0] s);
    logic [WIDE_W-1:0] half;
    half = {{(WIDE_W-1){1'b0}}, 1'b1} << (s - SHIFT_W'(1));
    if (s == '0) return x;
    else return (x + half) >> s;
  endfunction

  // Saturate to the largest legal stored sum.
  function automatic logic [OUT_W-1:0] clip_sat(input logic [WIDE_W-1:0] x);
    if (x > CLIP_LIM) return OUT_W'(CLIP_LIM);
    else return OUT_W'(x);
  endfunction

  logic                    vld_p0, vld_p1;
  logic [COH_W-1:0]        abs_i_p0, abs_q_p0;
  logic [SHIFT_W-1:0]      s_p0, s_p1;
  logic                    fs_p0, fs_p1, fp_p0, fp_p1;
  logic [1:0]              xs_p0, xs_p1;
  logic [AMP_W-1:0]        amp_p1;
  logic [COH_W-1:0]        mx_p0, mn_p0;

  logic [WIDE_W-1:0]       coh_term, nc_term, sum_full, scaled;
  logic [OUT_W-1:0]        clip_val;
  logic [IDX_W-1:0]        idx_cnt;

  // ---- stage 1 boundary: magnitudes and sample tags
  // Valid pipeline, cleared asynchronously so in-flight samples are dropped.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= coh_valid;
      vld_p1 <= vld_p0;
    end
  end

  // Stage 1 data: saturated magnitudes, coherent shift and per-sample tags.
  always_ff @(posedge clk) begin
    abs_i_p0 <= abs_sat(coh_i);
    abs_q_p0 <= abs_sat(coh_q);
    s_p0     <= coh_shift - coh_exp;
    fs_p0    <= frame_start;
    fp_p0    <= first_pass;
    xs_p0    <= extra_shift;
  end

  // ---- stage 2 boundary: amplitude estimate
  assign mx_p0 = (abs_i_p0 >= abs_q_p0) ? abs_i_p0 : abs_q_p0;
  assign mn_p0 = (abs_i_p0 >= abs_q_p0) ? abs_q_p0 : abs_i_p0;

  // Stage 2 data: max + min/2 amplitude, tags forwarded.
  always_ff @(posedge clk) begin
    amp_p1 <= AMP_W'(mx_p0) + AMP_W'(mn_p0 >> 1);
    s_p1   <= s_p0;
    fs_p1  <= fs_p0;
    fp_p1  <= fp_p0;
    xs_p1  <= xs_p0;
  end

  // ---- stage 3 boundary: scaling, accumulation, clip, output registers
  assign coh_term = rnd_shr(WIDE_W'(amp_p1), s_p1);
  assign nc_term  = fp_p1 ? '0 : rnd_shr(WIDE_W'(noncoh_data), noncoh_shift);
  assign sum_full = coh_term + nc_term;
  assign scaled   = rnd_shr(sum_full, SHIFT_W'(xs_p1));
  assign clip_val = clip_sat(scaled);
  assign exceed   = clip_val[NC_W];

  // Output sample register plus per-frame peak tracking and exceed counting.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid  <= 1'b0;
      noncoh_out <= '0;
      peak_value <= '0;
      peak_index <= '0;
      exceed_cnt <= '0;
      idx_cnt    <= '0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        noncoh_out <= clip_val;
        if (fs_p1) begin
          peak_value <= clip_val;
          peak_index <= '0;
          idx_cnt    <= '0;
          exceed_cnt <= CNT_W'(clip_val[NC_W]);
        end else begin
          idx_cnt <= idx_cnt + IDX_W'(1);
          if (clip_val > peak_value) begin
            peak_value <= clip_val;
            peak_index <= idx_cnt + IDX_W'(1);
          end
          if (clip_val[NC_W] && (exceed_cnt != CNT_MAX))
            exceed_cnt <= exceed_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_noncoh_acc_core.sv
// Directed bench for noncoh_acc_core: single-sample latency/scaling cases,
// a short frame for peak tracking, reset mid-flight, and counter saturation.
module tb_noncoh_acc_core;

  localparam int COH_W   = 10;
  localparam int NC_W    = 8;
  localparam int SHIFT_W = 4;
  localparam int IDX_W   = 10;
  localparam int CNT_W   = 8;

  logic                      clk = 1'b0;
  logic                      rst_b;
  logic                      coh_valid;
  logic signed [COH_W-1:0]   coh_i, coh_q;
  logic        [SHIFT_W-1:0] coh_exp, coh_shift;
  logic                      frame_start, first_pass;
  logic        [1:0]         extra_shift;
  logic        [NC_W-1:0]    noncoh_data;
  logic        [SHIFT_W-1:0] noncoh_shift;
  logic                      out_valid;
  logic        [NC_W:0]      noncoh_out;
  logic                      exceed;
  logic        [NC_W:0]      peak_value;
  logic        [IDX_W-1:0]   peak_index;
  logic        [CNT_W-1:0]   exceed_cnt;

  int errors = 0;
  int checks = 0;

  noncoh_acc_core #(
    .COH_W(COH_W), .NC_W(NC_W), .SHIFT_W(SHIFT_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_b(rst_b), .coh_valid(coh_valid), .coh_i(coh_i), .coh_q(coh_q),
    .coh_exp(coh_exp), .coh_shift(coh_shift), .frame_start(frame_start),
    .first_pass(first_pass), .extra_shift(extra_shift), .noncoh_data(noncoh_data),
    .noncoh_shift(noncoh_shift), .out_valid(out_valid), .noncoh_out(noncoh_out),
    .exceed(exceed), .peak_value(peak_value), .peak_index(peak_index),
    .exceed_cnt(exceed_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample: checks latency, exceed in cycle t+2, and output at t+3.
  task automatic run1(input int i, input int q, input int e, input int sh,
                      input int fs, input int fp, input int xs, input int nd,
                      input int ns, input int exp_out, input int exp_exc,
                      input string tag);
    coh_i = COH_W'(i);  coh_q = COH_W'(q);
    coh_exp = SHIFT_W'(e); coh_shift = SHIFT_W'(sh);
    frame_start = fs[0]; first_pass = fp[0]; extra_shift = xs[1:0];
    coh_valid = 1'b1;
    cyc();
    coh_valid = 1'b0;
    chk({tag, "_vld_t1"}, out_valid, 0);
    cyc();
    noncoh_data = NC_W'(nd); noncoh_shift = SHIFT_W'(ns);
    #1;
    chk({tag, "_exceed"}, exceed, exp_exc);
    chk({tag, "_vld_t2"}, out_valid, 0);
    cyc();
    chk({tag, "_vld_t3"}, out_valid, 1);
    chk({tag, "_out"}, noncoh_out, exp_out);
  endtask

  initial begin
    rst_b = 1'b0; coh_valid = 1'b0; coh_i = '0; coh_q = '0;
    coh_exp = '0; coh_shift = '0; frame_start = 1'b0; first_pass = 1'b0;
    extra_shift = '0; noncoh_data = '0; noncoh_shift = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_noncoh_out", noncoh_out, 0);
    chk("rst_peak_value", peak_value, 0);
    chk("rst_peak_index", peak_index, 0);
    chk("rst_exceed_cnt", exceed_cnt, 0);
    cyc(); cyc();
    rst_b = 1'b1;
    cyc();

    // 300 + 100/2 = 350, stored sum ignored on first pass
    run1(300, -100, 0, 0, 1, 1, 0, 77, 0, 350, 1, "basic_fp");
    chk("basic_peak", peak_value, 350);
    chk("basic_idx", peak_index, 0);
    chk("basic_cnt", exceed_cnt, 1);
    // 511 + 255 + 200 = 966 -> clip 510; with extra shift (966+1)>>1 = 483
    run1(-512, -512, 0, 0, 1, 0, 0, 200, 0, 510, 1, "clip");
    run1(-512, -512, 0, 0, 1, 0, 1, 200, 0, 483, 1, "clip_xs1");
    // (7+1)>>1 = 4, (5+1)>>1 = 3
    run1(7, 0, 0, 1, 1, 0, 0, 5, 1, 7, 0, "shift1");
    // s = 2-5 = 13 -> coherent 0, total 3; below peak of 7
    run1(7, 0, 5, 2, 0, 0, 0, 5, 1, 3, 0, "shift13");
    chk("s13_peak", peak_value, 7);
    chk("s13_idx", peak_index, 0);
    chk("s13_cnt", exceed_cnt, 0);
    // |Q| larger: 101 + 20/2 = 111, (3+1)>>1 = 2 -> 113, new peak at index 2
    run1(-20, 101, 0, 0, 0, 0, 0, 3, 1, 113, 0, "qmax");
    chk("qmax_peak", peak_value, 113);
    chk("qmax_idx", peak_index, 2);

    // Frame of back-to-back outputs 10,40,40,20
    noncoh_data = 8'd255; noncoh_shift = '0; coh_q = '0;
    coh_exp = '0; coh_shift = '0; first_pass = 1'b1; extra_shift = '0;
    coh_valid = 1'b1; frame_start = 1'b1; coh_i = 10'sd10;
    cyc();
    frame_start = 1'b0; coh_i = 10'sd40;
    cyc();
    coh_i = 10'sd40;
    cyc();
    coh_i = 10'sd20;
    chk("frame_first_out", noncoh_out, 10);
    chk("frame_first_vld", out_valid, 1);
    cyc();
    coh_valid = 1'b0;
    cyc(); cyc();
    chk("frame_last_out", noncoh_out, 20);
    chk("frame_last_vld", out_valid, 1);
    cyc();
    chk("frame_idle_vld", out_valid, 0);
    chk("frame_hold_out", noncoh_out, 20);
    chk("frame_peak", peak_value, 40);
    chk("frame_idx", peak_index, 1);
    chk("frame_cnt", exceed_cnt, 0);
    run1(5, 0, 0, 0, 1, 1, 0, 0, 0, 5, 0, "frame2");
    chk("frame2_peak", peak_value, 5);
    chk("frame2_idx", peak_index, 0);

    // Reset with samples in flight
    coh_i = -10'sd512; coh_q = -10'sd512; frame_start = 1'b1; first_pass = 1'b1;
    coh_valid = 1'b1;
    cyc(); cyc();
    #2;
    rst_b = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_out", noncoh_out, 0);
    chk("mid_rst_peak", peak_value, 0);
    chk("mid_rst_idx", peak_index, 0);
    chk("mid_rst_cnt", exceed_cnt, 0);
    coh_valid = 1'b0;
    cyc(); cyc();
    rst_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("post_rst_quiet", out_valid, 0);
    end
    run1(300, -100, 0, 0, 1, 1, 0, 0, 0, 350, 1, "post_rst");

    // 300 consecutive clipped outputs: counter saturates
    coh_i = -10'sd512; coh_q = -10'sd512; first_pass = 1'b1; extra_shift = '0;
    coh_exp = '0; coh_shift = '0; frame_start = 1'b1; coh_valid = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (299) cyc();
    coh_valid = 1'b0;
    cyc(); cyc();
    chk("sat_vld", out_valid, 1);
    chk("sat_out", noncoh_out, 510);
    chk("sat_cnt", exceed_cnt, 255);
    chk("sat_peak", peak_value, 510);
    chk("sat_idx", peak_index, 0);
    cyc();
    chk("sat_idle_vld", out_valid, 0);
    chk("sat_hold_cnt", exceed_cnt, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
